alu_op_sequencer: RTL and testbench

- Initiator-side master for the 8-bit register-file/ALU datapath.
- Accepts one operation at a time from a command-issuing controller over a valid/ready command port.
- Drives operands and opcode into the register file, waits a fixed number of cycles for the result, then samples the result word, the multiply high byte and the flags.
- Returns the sample as a packed 16-bit response on a valid/ready response port.

---
 rtl/alu_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator-side master for the 8-bit register-file/ALU
// datapath. It takes one command at a time, drives the operands and opcode
// into the register file, and waits WAIT_CYCLES edges for the result. It
// then samples the result, the product high byte and the flags, and returns
// them as a packed 16-bit response.
//
// Optional build macro: ALU_PERF_CNT_EN. When it is defined, perf_count
// counts completed response handshakes. When it is not defined, perf_count
// is tied to zero and no counter is built.
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command; cmd_ready high (except during reset)
// WAIT  | operands driven; down-counter running toward the sample edge
// RESP  | response held on rsp_*; waiting for rsp_ready

module alu_op_sequencer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [1:0]  cmd_op,
    output logic [7:0]  rf_inreg1,
    output logic [7:0]  rf_inreg2,
    output logic [1:0]  rf_opcode,
    input  logic [7:0]  rf_store_word,
    input  logic [7:0]  rf_store_inp1,
    input  logic        rf_carry,
    input  logic        rf_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic [1:0]  rsp_op,
    output logic        busy,
    output logic [15:0] perf_count
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("alu_op_sequencer: WAIT_CYCLES must be within 1..15");
    end

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [1:0] OP_MUL    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [1:0] op_q;
    logic       accept;
    logic       sample;
    logic       rsp_done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        rsp_done  = 1'b0;
        cmd_ready = (state == ST_IDLE) && !rst;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter reaches zero on this edge: this is the sample edge
                if (wait_cnt == 4'd1) begin
                    sample    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand drive, wait counter and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_inreg1    <= 8'h00;
            rf_inreg2    <= 8'h00;
            rf_opcode    <= 2'd0;
            op_q         <= 2'd0;
            wait_cnt     <= 4'd0;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= 16'h0000;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_op       <= 2'd0;
        end else begin
            if (accept) begin
                rf_inreg1 <= cmd_a;
                rf_inreg2 <= cmd_b;
                rf_opcode <= cmd_op;
                op_q      <= cmd_op;
                wait_cnt  <= WAIT_LOAD;
                busy      <= 1'b1;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (sample) begin
                rsp_result   <= (op_q == OP_MUL) ? {rf_store_inp1, rf_store_word}
                                                 : {8'h00, rf_store_word};
                rsp_carry    <= rf_carry;
                rsp_overflow <= rf_overflow;
                rsp_op       <= op_q;
                rsp_valid    <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

`ifdef ALU_PERF_CNT_EN
    // Completed-operation counter; wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_count <= 16'h0000;
        end else if (rsp_done) begin
            perf_count <= perf_count + 16'd1;
        end
    end
`else
    assign perf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. A bit-level register-file model feeds the
// DUT, and expected responses come from an integer-arithmetic reference.
module tb_alu_op_sequencer;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [1:0]  cmd_op;
    logic [7:0]  rf_inreg1;
    logic [7:0]  rf_inreg2;
    logic [1:0]  rf_opcode;
    logic [7:0]  rf_store_word;
    logic [7:0]  rf_store_inp1;
    logic        rf_carry;
    logic        rf_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic [1:0]  rsp_op;
    logic        busy;
    logic [15:0] perf_count;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_count = 0;

    alu_op_sequencer #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .rf_inreg1(rf_inreg1), .rf_inreg2(rf_inreg2), .rf_opcode(rf_opcode),
        .rf_store_word(rf_store_word), .rf_store_inp1(rf_store_inp1),
        .rf_carry(rf_carry), .rf_overflow(rf_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow), .rsp_op(rsp_op),
        .busy(busy), .perf_count(perf_count)
    );

    always #5 clk = ~clk;

    // Register-file model: op0 add, op1 sub (carry = borrow), op2 and, op3 mul.
    // Non-multiply ops leave junk on the high byte so packing is exercised.
    always_comb begin
        logic [8:0]  t9;
        logic [15:0] p;
        t9 = 9'd0;
        p = 16'd0;
        rf_store_word = 8'h00;
        rf_store_inp1 = rf_inreg1 ^ 8'hA5;
        rf_carry      = 1'b0;
        rf_overflow   = 1'b0;
        case (rf_opcode)
            2'd0: begin
                t9 = {1'b0, rf_inreg1} + {1'b0, rf_inreg2};
                rf_store_word = t9[7:0];
                rf_carry      = t9[8];
                rf_overflow   = (rf_inreg1[7] == rf_inreg2[7]) && (t9[7] != rf_inreg1[7]);
            end
            2'd1: begin
                t9 = {1'b0, rf_inreg1} - {1'b0, rf_inreg2};
                rf_store_word = t9[7:0];
                rf_carry      = t9[8];
                rf_overflow   = (rf_inreg1[7] != rf_inreg2[7]) && (t9[7] != rf_inreg1[7]);
            end
            2'd2: rf_store_word = rf_inreg1 & rf_inreg2;
            default: begin
                p = rf_inreg1 * rf_inreg2;
                rf_store_word = p[7:0];
                rf_store_inp1 = p[15:8];
                rf_carry      = |p[15:8];
            end
        endcase
    end

    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                                   output logic [15:0] res, output logic c, output logic v);
        int ia, ib, sa, sb, s, ss;
        ia = int'(a); ib = int'(b);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        c = 1'b0; v = 1'b0; res = 16'h0000;
        case (op)
            2'd0: begin
                s = ia + ib; res = 16'(s % 256); c = (s > 255);
                ss = sa + sb; v = (ss > 127) || (ss < -128);
            end
            2'd1: begin
                s = ia - ib; res = 16'((s + 256) % 256); c = (ia < ib);
                ss = sa - sb; v = (ss > 127) || (ss < -128);
            end
            2'd2: res = 16'(ia & ib);
            default: begin
                s = ia * ib; res = 16'(s); c = (s > 255);
            end
        endcase
    endfunction

    function automatic logic [15:0] exp_perf();
`ifdef ALU_PERF_CNT_EN
        return 16'(hs_count);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits for rsp_valid at negedges; returns number of edges waited
    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full operation; hold = cycles of backpressure after rsp_valid
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input int hold);
        logic [15:0] er;
        logic ec, ev;
        int n;
        ref_op(a, b, op, er, ec, ev);
        rsp_ready = (hold == 0);
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_op = ~op;
        chk("rf_drive", {14'd0, rf_opcode, rf_inreg1, rf_inreg2}, {14'd0, op, a, b});
        chk("busy_cmd_ready_wait", {busy, cmd_ready}, 32'b10);
        wait_rsp(n);
        chk("sample_latency", 32'(n), 32'(W));
        chk("rsp_result", 32'(rsp_result), 32'(er));
        chk("rsp_flags_op", {rsp_carry, rsp_overflow, rsp_op}, {ec, ev, op});
        chk("busy_resp", {busy, cmd_ready}, 32'b10);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_hold", {rsp_valid, cmd_ready, rsp_carry, rsp_overflow, rsp_result},
                {1'b1, 1'b0, ec, ev, er});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        hs_count++;
        chk("after_handshake", {rsp_valid, busy, cmd_ready, rsp_result}, {3'b001, er});
        chk("perf_count", 32'(perf_count), 32'(exp_perf()));
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic [15:0] res;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[8];
    int acc_cyc[$];
    logic [15:0] exp_q[$];

    initial begin
        int n;
        vecs[0] = '{8'h7F, 8'h01, 2'd0, 16'h0080, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'hFF, 2'd3, 16'hFE01, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 2'd0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 2'd1, 16'h00FE, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 2'd1, 16'h007F, 1'b0, 1'b1};
        vecs[5] = '{8'h0F, 8'hF3, 2'd2, 16'h0003, 1'b0, 1'b0};
        vecs[6] = '{8'h10, 8'h20, 2'd3, 16'h0200, 1'b1, 1'b0};
        vecs[7] = '{8'h03, 8'h04, 2'd3, 16'h000C, 1'b0, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 2'd0; rsp_ready = 1'b0;
        #2;
        chk("reset_outputs", {cmd_ready, busy, rsp_valid, rsp_result, rf_inreg1},
            {3'b000, 16'h0000, 8'h00});
        chk("reset_misc", {rf_inreg2, rf_opcode, rsp_op, rsp_carry, rsp_overflow, perf_count},
            {8'h00, 2'd0, 2'd0, 2'b00, 16'h0000});
        @(negedge clk); rst = 1'b0;

        // Table vectors: reference model and constants must agree, then the DUT must too
        for (int i = 0; i < 8; i++) begin
            logic [15:0] r; logic c, v;
            ref_op(vecs[i].a, vecs[i].b, vecs[i].op, r, c, v);
            chk("vec_table_vs_model", {r, c, v}, {vecs[i].res, vecs[i].c, vecs[i].v});
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, 0);
        end

        // Backpressure with a second command held pending
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_a = 8'hFF; cmd_b = 8'h01; cmd_op = 2'd0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 2'd1;
        wait_rsp(n);
        chk("bp_latency", 32'(n), 32'(W));
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {rsp_valid, cmd_ready, rsp_carry, rsp_result, rf_inreg1},
                {3'b101, 16'h0000, 8'hFF});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        hs_count++;
        chk("bp_release", {rsp_valid, cmd_ready, rf_inreg1}, {2'b01, 8'hFF});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_accept", {busy, rf_inreg1, rf_inreg2, rf_opcode}, {1'b1, 8'h11, 8'h22, 2'd1});
        wait_rsp(n);
        chk("bp_second_result", {rsp_result, rsp_carry, rsp_op}, {16'h00EF, 1'b1, 2'd1});
        @(negedge clk);
        hs_count++;
        chk("bp_perf", 32'(perf_count), 32'(exp_perf()));

        // Randomized operations with random backpressure
        for (int i = 0; i < 25; i++) begin
            run_op(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset one cycle after accept aborts the operation
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 2'd0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        hs_count = 0;
        chk("rst_mid_wait", {rsp_valid, busy, cmd_ready, rf_inreg1, rf_inreg2, rf_opcode, perf_count},
            {3'b000, 8'h00, 8'h00, 2'd0, 16'h0000});
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) n++;
        end
        chk("no_rsp_after_rst", 32'(n), 32'd0);

        // Back-to-back: three commands, valid and ready held high
        for (int i = 0; i < 3; i++) begin
            logic [15:0] r; logic c, v;
            ref_op(vecs[i].a, vecs[i].b, vecs[i].op, r, c, v);
            exp_q.push_back(r);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_a = vecs[0].a; cmd_b = vecs[0].b; cmd_op = vecs[0].op; cmd_valid = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rsp_valid === 1'b1) begin
                logic [15:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                chk("b2b_result", 32'(rsp_result), 32'(e));
                hs_count++;
            end
            if (cmd_valid && cmd_ready === 1'b1) begin
                acc_cyc.push_back(cyc);
                n++;
            end
            @(negedge clk);
            if (n < 3 && cmd_ready !== 1'b1) begin
                cmd_a = vecs[n].a; cmd_b = vecs[n].b; cmd_op = vecs[n].op;
            end
            if (n >= 3) cmd_valid = 1'b0;
        end
        chk("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
            chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
        end
        chk("b2b_all_rsp", 32'(exp_q.size()), 32'd0);
        chk("b2b_perf", 32'(perf_count), 32'(exp_perf()));
`ifdef ALU_PERF_CNT_EN
        chk("b2b_perf_3", 32'(perf_count), 32'd3);
`else
        chk("b2b_perf_0", 32'(perf_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
